psoa_logit: RTL and testbench
=============================

Name: psoa_logit

Overview:
- Inverse of psoa_sigmoid: takes a probability y (unsigned Q0.10, 1.0 = 1024) and returns x (signed Q5.10) such that psoa_sigmoid(x) ≈ y.
- Instantiates psoa_sigmoid as its forward model and runs an MSB-first bisection on the magnitude of x.
- Folds y about 0.5 so the search only ever drives non-negative x, the same folding the sigmoid bench does in software.
- Sits after any sigmoid stage that needs its pre-activation recovered; also serves as the round-trip checker for psoa_sigmoid.

Parameters:
- MAG_BITS, 13, magnitude width of x; the search range is [0, 2^MAG_BITS-1] = [0, 8191] ≈ [0, 8.0).
- FRAC_BITS, 10, fractional bits of both y and x; ONE = 2^FRAC_BITS = 1024.
- SIG_LAT, 1, clock cycles from a value on psoa_sigmoid.x to a valid psoa_sigmoid.f_x.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  y_in is valid.
- in_ready  out  1  block is idle and accepts y_in.
- y_in  in  16  probability, unsigned Q0.10; values above 1024 are clamped to 1024.
- out_valid  out  1  x_out and sat are valid.
- out_ready  in  1  downstream accepts the result.
- x_out  out  16  signed two's-complement Q5.10 result.
- sat  out  1  |x_out| = 8191, i.e. the search hit the range limit.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset_n = 0:
  - state = IDLE, in_ready = 0, out_valid = 0, x_out = 0, sat = 0.
  - The internal candidate driven to psoa_sigmoid is 0.
  - in_ready rises on the first clk edge after reset_n deasserts.
- Reset mid-search: aborts immediately; the result is discarded, with no partial output.
- Handshake:
  - Accept when in_valid && in_ready. in_ready = 1 only in IDLE.
  - Result transfers when out_valid && out_ready.
  - out_valid, x_out and sat stay stable until that transfer.
  - in_ready is not asserted in the cycle of the output transfer; the block returns to IDLE on the next edge.
- FSM states: IDLE -> FOLD -> {DRIVE -> WAIT -> CMP} x MAG_BITS -> DONE -> IDLE.
- IDLE: on accept, register yc = min(y_in, 1024).
- FOLD (1 cycle):
  - If yc >= 512: t = yc, neg = 0.
  - Else: t = 1024 - yc, neg = 1.
  - Clear m = 0, set b = MAG_BITS-1. t is always in [512, 1024].
- DRIVE (1 cycle): register c = m | (1<<b) onto psoa_sigmoid.x.
- WAIT (SIG_LAT cycles): hold c.
- CMP (1 cycle):
  - If f_x <= t, set m = c.
  - If b = 0, go to DONE; else decrement b and go to DRIVE.
- Comparison is unsigned 16-bit. psoa_sigmoid is required to be monotone non-decreasing on [0, 8191].
- m ends as the largest magnitude with f(m) <= t (floor search).
- DONE:
  - x_out = neg ? -m : m, a 16-bit two's-complement value.
  - sat = (m == 8191).
  - out_valid = 1.
- Latency, accept edge to out_valid high: 1 + MAG_BITS*(SIG_LAT+2) cycles, i.e. 40 at the defaults. This is fixed and independent of data.
- Boundary cases:
  - y_in = 0 -> x_out = -8191, sat = 1.
  - y_in >= 1024 -> x_out = +8191, sat = 1.
  - y_in = 512 -> neg = 0, x_out >= 0.
- Symmetry: for 0 < y < 512, x_out(y) = -x_out(1024 - y) exactly.
- in_valid asserted while busy is ignored; no queueing.

Optional Feature:
- Macro: PSOA_LOGIT_ROUND_EN.
- When defined:
  - After the last CMP, if m < 8191, one extra DRIVE/WAIT/CMP evaluates f(m+1).
  - If |f(m+1) - t| < |t - f(m)|, then m = m+1 (round to nearest; ties keep m).
  - Latency becomes 1 + (MAG_BITS+1)*(SIG_LAT+2) = 43 at the defaults, also when m = 8191 (a dummy evaluation keeps latency fixed).
- When undefined: floor result with the latency above.
- Ports are identical in both builds.

Test Plan:
- Reset, then y_in = 881 with out_ready = 1 -> out_valid exactly 40 cycles after accept; x_out within ±16 LSB of 1862 (logit(0.8604)·1024); sat = 0.
- y_in = 143 -> x_out equals the exact two's-complement negation of the 881 result; y_in = 512 -> x_out in [0, 4].
- y_in = 0 -> x_out = 0xE001 (-8191), sat = 1; y_in = 1024 and y_in = 2000 -> x_out = 8191, sat = 1.
- out_ready held 0 for 10 cycles after out_valid -> out_valid, x_out and sat unchanged, in_ready = 0, a new in_valid is ignored; the result transfers on the first out_ready = 1.
- reset_n pulsed low 20 cycles into a search -> outputs clear immediately with no spurious out_valid; the next request gives a correct 40-cycle result.
- Sweep y = 1..1023: round trip |psoa_sigmoid(x_out) - y| <= 1 LSB; with PSOA_LOGIT_ROUND_EN, no result is farther from y than its neighbour m±1, and latency is 43.

Source files
------------

// File: rtl/psoa_logit.sv
`default_nettype none
// psoa_logit: inverse sigmoid by MSB-first bisection of |x| against psoa_sigmoid.
// Optional macro PSOA_LOGIT_ROUND_EN adds one extra evaluation that rounds to nearest.

module psoa_logit #(
  parameter int MAG_BITS  = 13,
  parameter int FRAC_BITS = 10,
  parameter int SIG_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x_out,
  output logic        sat
);

  localparam int TW = FRAC_BITS + 1;
  localparam int BW = $clog2(MAG_BITS);
  localparam int WW = $clog2(SIG_LAT + 1);
  localparam logic [TW-1:0]       ONE     = TW'(1 << FRAC_BITS);
  localparam logic [TW-1:0]       HALF    = TW'(1 << (FRAC_BITS - 1));
  localparam logic [MAG_BITS-1:0] MAG_MAX = '1;

  typedef enum logic [2:0] {IDLE, FOLD, DRIVE, WAIT, CMP, DONE} state_t;

  state_t              state_q;
  logic [TW-1:0]       yc_q, t_q;
  logic                neg_q, rnd_q, in_ready_q, out_valid_q, sat_q;
  logic [MAG_BITS-1:0] m_q, c_q, m_d;
  logic [15:0]         fm_q, fm_d, x_out_q;
  logic [BW-1:0]       b_q;
  logic [WW-1:0]       w_q;
  logic [15:0]         f_x, t_ext, d1, d0, x_mag;
  logic                take, round_up, last_cmp, go_round;

  psoa_sigmoid #(.LAT(SIG_LAT)) u_sig (
    .clk    (clk),
    .reset_n(reset_n),
    .x      (16'(c_q)),
    .f_x    (f_x)
  );

  always_comb begin
    t_ext    = 16'(t_q);
    take     = (f_x <= t_ext);
    d1       = (f_x >= t_ext) ? (f_x - t_ext) : (t_ext - f_x);
    d0       = t_ext - fm_q;
    // c_q == m_q marks the dummy evaluation issued when m is already at the limit
    round_up = (c_q != m_q) && (d1 < d0);
    m_d      = m_q;
    fm_d     = fm_q;
    if (state_q == CMP) begin
      if (rnd_q) begin
        if (round_up) begin
          m_d  = c_q;
          fm_d = f_x;
        end
      end else if (take) begin
        m_d  = c_q;
        fm_d = f_x;
      end
    end
    x_mag = 16'(m_d);
`ifdef PSOA_LOGIT_ROUND_EN
    last_cmp = (state_q == CMP) && rnd_q;
    go_round = (state_q == CMP) && !rnd_q && (b_q == '0);
`else
    last_cmp = (state_q == CMP) && (b_q == '0);
    go_round = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      yc_q        <= '0;
      t_q         <= '0;
      neg_q       <= 1'b0;
      rnd_q       <= 1'b0;
      m_q         <= '0;
      fm_q        <= '0;
      c_q         <= '0;
      b_q         <= '0;
      w_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      m_q  <= m_d;
      fm_q <= fm_d;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            yc_q       <= (y_in > 16'(ONE)) ? ONE : y_in[TW-1:0];
            in_ready_q <= 1'b0;
            state_q    <= FOLD;
          end
        end
        FOLD: begin
          if (yc_q >= HALF) begin
            t_q   <= yc_q;
            neg_q <= 1'b0;
          end else begin
            t_q   <= ONE - yc_q;
            neg_q <= 1'b1;
          end
          m_q     <= '0;
          // sigmoid(0) is one half; the rounding pass needs f(m) even if m stays 0
          fm_q    <= 16'(HALF);
          b_q     <= BW'(MAG_BITS - 1);
          rnd_q   <= 1'b0;
          state_q <= DRIVE;
        end
        DRIVE: begin
          if (rnd_q) c_q <= (m_q == MAG_MAX) ? m_q : m_q + MAG_BITS'(1);
          else       c_q <= m_q | (MAG_BITS'(1) << b_q);
          w_q     <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (w_q == WW'(SIG_LAT - 1)) state_q <= CMP;
          else                         w_q     <= w_q + WW'(1);
        end
        CMP: begin
          if (last_cmp) begin
            out_valid_q <= 1'b1;
            x_out_q     <= neg_q ? (~x_mag + 16'd1) : x_mag;
            sat_q       <= (m_d == MAG_MAX);
            state_q     <= DONE;
          end else if (go_round) begin
            rnd_q   <= 1'b1;
            state_q <= DRIVE;
          end else begin
            b_q     <= b_q - BW'(1);
            state_q <= DRIVE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign sat       = sat_q;

endmodule

// Forward model: 1/(1+e^-x) on Q5.10, linear interpolation between knots every 0.25.
module psoa_sigmoid #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x,
  output logic [15:0] f_x
);

  function automatic logic [10:0] knot(input logic [5:0] k);
    case (k)
      6'd0:  knot = 11'd512;   6'd1:  knot = 11'd576;   6'd2:  knot = 11'd637;
      6'd3:  knot = 11'd695;   6'd4:  knot = 11'd749;   6'd5:  knot = 11'd796;
      6'd6:  knot = 11'd837;   6'd7:  knot = 11'd872;   6'd8:  knot = 11'd902;
      6'd9:  knot = 11'd926;   6'd10: knot = 11'd946;   6'd11: knot = 11'd962;
      6'd12: knot = 11'd975;   6'd13: knot = 11'd986;   6'd14: knot = 11'd994;
      6'd15: knot = 11'd1000;  6'd16: knot = 11'd1006;  6'd17: knot = 11'd1010;
      6'd18: knot = 11'd1013;  6'd19: knot = 11'd1015;  6'd20: knot = 11'd1017;
      6'd21: knot = 11'd1019;  6'd22: knot = 11'd1020;  6'd23: knot = 11'd1021;
      6'd24: knot = 11'd1021;  6'd25: knot = 11'd1022;  6'd26: knot = 11'd1022;
      6'd27: knot = 11'd1023;  6'd28: knot = 11'd1023;  6'd29: knot = 11'd1023;
      6'd30: knot = 11'd1023;  default: knot = 11'd1024;
    endcase
  endfunction

  logic [15:0] mag, f_d;
  logic [12:0] mag_c;
  logic [10:0] lo, hi, pos;
  logic [18:0] prod;
  logic [15:0] pipe_q [LAT];

  always_comb begin
    mag   = x[15] ? (~x + 16'd1) : x;
    mag_c = (mag > 16'd8191) ? 13'd8191 : mag[12:0];
    lo    = knot({1'b0, mag_c[12:8]});
    hi    = knot({1'b0, mag_c[12:8]} + 6'd1);
    prod  = 19'(hi - lo) * 19'(mag_c[7:0]);
    pos   = lo + 11'(prod >> 8);
    f_d   = x[15] ? 16'(11'd1024 - pos) : 16'(pos);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= f_d;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign f_x = pipe_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_psoa_logit.sv
`default_nettype none
// tb_psoa_logit: scoreboard bench for psoa_logit with an exp()-derived sigmoid reference.

module tb_psoa_logit;

  localparam int MAG_BITS = 13;
  localparam int SIG_LAT  = 1;
  localparam int MAG_MAX  = (1 << MAG_BITS) - 1;
`ifdef PSOA_LOGIT_ROUND_EN
  localparam int LAT_EXP = 1 + (MAG_BITS + 1) * (SIG_LAT + 2);
`else
  localparam int LAT_EXP = 1 + MAG_BITS * (SIG_LAT + 2);
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] y_in = '0;
  logic        out_ready;
  logic        in_ready, out_valid, sat;
  logic [15:0] x_out;

  psoa_logit #(.MAG_BITS(MAG_BITS), .FRAC_BITS(10), .SIG_LAT(SIG_LAT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit hold = 1'b0, rnd_rdy = 1'b0;
  always @(negedge clk)
    out_ready = hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);

  typedef struct { int y; logic [15:0] x; bit s; int acc; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int last_x = 0;
  bit last_sat = 1'b0;
  int knot [0:32];
  int floor_of [0:1024];

  function automatic void chk(input bit ok, input string nm, input int act, input int expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sig_ref(input int x);
    int a, k, fr, v;
    a  = iabs(x);
    if (a > MAG_MAX) a = MAG_MAX;
    k  = a / 256;
    fr = a % 256;
    v  = knot[k] + ((knot[k+1] - knot[k]) * fr) / 256;
    return (x < 0) ? 1024 - v : v;
  endfunction

  // Largest magnitude whose sigmoid does not exceed the folded target, optionally rounded.
  function automatic int exp_x(input int y);
    int yc, t, m;
    yc = (y > 1024) ? 1024 : y;
    t  = (yc >= 512) ? yc : 1024 - yc;
    m  = floor_of[t];
`ifdef PSOA_LOGIT_ROUND_EN
    if (m < MAG_MAX && iabs(sig_ref(m + 1) - t) < iabs(t - sig_ref(m))) m++;
`endif
    return (yc >= 512) ? m : -m;
  endfunction

  task automatic issue(input int y);
    int g;
    int ex;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    y_in     = y[15:0];
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk(1'b0, "issue_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      ex = exp_x(y);
      exp_q.push_back('{y, 16'(ex), (iabs(ex) == MAG_MAX), cyc + 1});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk(exp_q.size() == 0 && in_ready, nm, exp_q.size(), 0);
  endtask

  initial begin : monitor
    bit prev_ov;
    int rise, xs, yc;
    exp_t e;
    prev_ov = 1'b0;
    rise    = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) rise = cyc;
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
          prev_ov = 1'b0;
          xs = int'($signed(x_out));
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_output", xs, 0);
          end else begin
            e  = exp_q.pop_front();
            yc = (e.y > 1024) ? 1024 : e.y;
            chk(x_out == e.x, "x_out", xs, int'($signed(e.x)));
            chk(sat == e.s, "sat", int'(sat), int'(e.s));
            chk(rise - e.acc == LAT_EXP, "latency", rise - e.acc, LAT_EXP);
            chk(iabs(sig_ref(xs) - yc) <= 1, "round_trip", sig_ref(xs), yc);
`ifdef PSOA_LOGIT_ROUND_EN
            chk(iabs(sig_ref(xs) - yc) <= iabs(sig_ref(xs + 1) - yc) &&
                iabs(sig_ref(xs) - yc) <= iabs(sig_ref(xs - 1) - yc),
                "nearest", xs, e.y);
`endif
            last_x   = xs;
            last_sat = sat;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int x881, sx, ss;
    int g;
    exp_t drop;

    for (int k = 0; k <= 32; k++)
      knot[k] = $rtoi(1024.0 / (1.0 + $exp(-real'(k) / 4.0)) + 0.5);
    for (int v = 0; v <= 1024; v++) floor_of[v] = -1;
    for (int m = 0; m <= MAG_MAX; m++) floor_of[sig_ref(m)] = m;
    for (int v = 1; v <= 1024; v++)
      if (floor_of[v] < floor_of[v-1]) floor_of[v] = floor_of[v-1];

    repeat (3) @(negedge clk);
    chk(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
    chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    chk(x_out == 16'd0 && sat == 1'b0, "rst_x_sat", int'(x_out), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk(in_ready == 1'b1, "in_ready_after_reset", int'(in_ready), 1);

    issue(881);  wait_idle("done_881");
    x881 = last_x;
    chk(iabs(x881 - 1862) <= 16, "x_881_near_1862", x881, 1862);
    chk(last_sat == 1'b0, "sat_881", int'(last_sat), 0);
    issue(143);  wait_idle("done_143");
    chk(last_x == -x881, "x_143_is_neg_881", last_x, -x881);
    issue(512);  wait_idle("done_512");
    chk(last_x >= 0 && last_x <= 4, "x_512_range", last_x, 0);
    issue(0);    wait_idle("done_0");
    chk(last_x == -8191 && last_sat, "x_0_is_E001", last_x, -8191);
    issue(1024); wait_idle("done_1024");
    chk(last_x == 8191 && last_sat, "x_1024", last_x, 8191);
    issue(2000); wait_idle("done_2000");
    chk(last_x == 8191 && last_sat, "x_2000", last_x, 8191);

    // Backpressure: result must hold while a second request is ignored
    hold = 1'b1;
    issue(300);
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    #2 chk(out_valid == 1'b1, "stall_valid_seen", int'(out_valid), 1);
    sx = int'(x_out);
    ss = int'(sat);
    in_valid = 1'b1;
    y_in     = 16'd700;
    repeat (10) begin
      @(negedge clk);
      #2;
      chk(out_valid == 1'b1 && int'(x_out) == sx && int'(sat) == ss, "stall_hold", int'(x_out), sx);
      chk(in_ready == 1'b0, "stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    wait_idle("stall_release");

    // Reset in the middle of a search
    issue(600);
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    drop = exp_q.pop_back();
    #1;
    chk(out_valid == 1'b0 && in_ready == 1'b0, "midrst_flags", int'(out_valid), 0);
    chk(x_out == 16'd0 && sat == 1'b0, "midrst_x_sat", int'(x_out), 0);
    repeat (3) begin
      @(negedge clk);
      #2 chk(out_valid == 1'b0, "midrst_no_valid", int'(out_valid), 0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk(in_ready == 1'b1, "in_ready_after_midrst", int'(in_ready), 1);
    issue(drop.y); wait_idle("done_after_midrst");

    // Random requests with random backpressure and gaps, then the full sweep
    rnd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 2047)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int y = 1; y <= 1023; y++) issue(y);
    wait_idle("done_sweep");
    rnd_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
